// File: rtl/fifo_wr_arbiter.sv
// Round-robin write-port arbiter sharing one FIFO among NUM_REQ producers; tracks FIFO occupancy.
// Build option FIFO_ARB_STRICT_PRIO_EN: fixed lowest-index-wins arbitration instead of round-robin.

module fifo_wr_arbiter_lane #(
  parameter int DATA_W = 8,
  parameter int GW     = 2,
  parameter int IDX    = 0
) (
  input  logic [GW-1:0]     grant_id,
  input  logic              grant_open,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              sel_valid,
  output logic [DATA_W-1:0] dout
);
  localparam logic [GW-1:0] ID = GW'(IDX);

  logic sel;
  assign sel       = (grant_id == ID);
  assign ready     = sel & grant_open;
  assign sel_valid = sel & valid;
  assign dout      = sel ? data : '0;
endmodule

module fifo_wr_arbiter #(
  parameter  int NUM_REQ      = 4,
  parameter  int DATA_W       = 8,
  parameter  int MAX_BURST    = 4,
  parameter  int USABLE_DEPTH = 7,
  localparam int GW           = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic                      fifo_full,
  input  logic                      fifo_empty,
  input  logic                      fifo_rd_enb,
  output logic                      fifo_wr_enb,
  output logic [DATA_W-1:0]         fifo_data_in,
  output logic [GW-1:0]             grant_id,
  output logic                      busy,
  output logic [3:0]                level
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t                          state;
  logic   [GW-1:0]                 rr_ptr;
  logic   [3:0]                    beat_cnt;
  logic                            grant_open;
  logic                            beat;
  logic                            cur_valid;
  logic   [NUM_REQ-1:0]            lane_sel_valid;
  logic   [NUM_REQ-1:0][DATA_W-1:0] lane_dout;
  logic   [GW-1:0]                 pick;
  logic   [GW-1:0]                 next_ptr;
  logic                            wr_acc;
  logic                            rd_acc;

  // Reset gates the write so a beat presented in the reset cycle is dropped.
  assign grant_open = (state == GRANT) & ~fifo_full & ~rst;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    fifo_wr_arbiter_lane #(.DATA_W(DATA_W), .GW(GW), .IDX(i)) u_lane (
      .grant_id  (grant_id),
      .grant_open(grant_open),
      .valid     (req_valid[i]),
      .data      (req_data[i*DATA_W +: DATA_W]),
      .ready     (req_ready[i]),
      .sel_valid (lane_sel_valid[i]),
      .dout      (lane_dout[i])
    );
  end

  assign beat        = |(req_ready & req_valid);
  assign cur_valid   = |lane_sel_valid;
  assign fifo_wr_enb = beat;

  always_comb begin
    fifo_data_in = '0;
    for (int i = 0; i < NUM_REQ; i++) fifo_data_in = fifo_data_in | lane_dout[i];
  end

  // First valid index at or after rr_ptr, wrapping; rr_ptr stays 0 in strict mode.
  always_comb begin
    logic [GW:0] sum;
    logic        found;
    pick  = '0;
    found = 1'b0;
    sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(k);
      if (sum >= (GW+1)'(NUM_REQ)) sum = sum - (GW+1)'(NUM_REQ);
      if (!found && req_valid[sum[GW-1:0]]) begin
        found = 1'b1;
        pick  = sum[GW-1:0];
      end
    end
  end

  assign next_ptr = (grant_id == GW'(NUM_REQ-1)) ? '0 : grant_id + GW'(1);

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rr_ptr   <= '0;
      grant_id <= '0;
      beat_cnt <= '0;
      busy     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req_valid) begin
            grant_id <= pick;
            beat_cnt <= '0;
            state    <= GRANT;
            busy     <= 1'b1;
          end
        end
        GRANT: begin
          if (!cur_valid || (beat && beat_cnt == 4'(MAX_BURST-1))) begin
            state <= IDLE;
            busy  <= 1'b0;
`ifdef FIFO_ARB_STRICT_PRIO_EN
            rr_ptr <= '0;
`else
            rr_ptr <= next_ptr;
`endif
          end else if (beat) begin
            beat_cnt <= beat_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign wr_acc = fifo_wr_enb & ~fifo_full;
  assign rd_acc = fifo_rd_enb & ~fifo_empty;

  always_ff @(posedge clk) begin
    if (rst)
      level <= '0;
    else if (wr_acc && !rd_acc && level != 4'(USABLE_DEPTH))
      level <= level + 4'd1;
    else if (rd_acc && !wr_acc && level != 4'd0)
      level <= level - 4'd1;
  end
endmodule
